// File: rtl/mem_pkg.sv
// Shared types for the memory-stage access controller: size codes, FSM states
// and the byte-enable / alignment helpers.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE  = 2'b00;
  localparam logic [1:0] SIZE_HALF  = 2'b01;
  localparam logic [1:0] SIZE_WORD  = 2'b10;
  localparam logic [1:0] SIZE_DWORD = 2'b11;

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1, DONE} state_e;

  function automatic logic [3:0] be_gen(input logic [1:0] size, input logic [1:0] addr_lo);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << addr_lo;
      SIZE_HALF: be = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:   be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic misaligned(input logic [1:0] size, input logic [2:0] addr_lo);
    logic m;
    case (size)
      SIZE_BYTE: m = 1'b0;
      SIZE_HALF: m = addr_lo[0];
      SIZE_WORD: m = |addr_lo[1:0];
      default:   m = |addr_lo;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mem_stage_access_ctrl_if.sv
// Data-memory beat port: request/ack with word address, byte enables and data.
interface mem_stage_access_ctrl_if;
  logic        Mem_Req_Out;
  logic        Mem_Write_Out;
  logic [31:0] Mem_Addr_Out;
  logic [3:0]  Mem_BE_Out;
  logic [31:0] Mem_WData_Out;
  logic        Mem_Ack_In;
  logic [31:0] Mem_RData_In;

  modport master (
    output Mem_Req_Out, Mem_Write_Out, Mem_Addr_Out, Mem_BE_Out, Mem_WData_Out,
    input  Mem_Ack_In, Mem_RData_In
  );

  modport slave (
    input  Mem_Req_Out, Mem_Write_Out, Mem_Addr_Out, Mem_BE_Out, Mem_WData_Out,
    output Mem_Ack_In, Mem_RData_In
  );
endinterface

// File: rtl/mem_lane_align.sv
// Combinational lane steering: byte enables, store-lane replication and
// load extraction with zero extension.
module mem_lane_align (
  input  logic [1:0]  size_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);
  import mem_pkg::*;

  always_comb begin
    be_o    = be_gen(size_i, addr_lo_i);
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    case (size_i)
      SIZE_BYTE: begin
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {24'd0, rdata_i[{addr_lo_i, 3'b000} +: 8]};
      end
      SIZE_HALF: begin
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {16'd0, rdata_i[{addr_lo_i[1], 4'b0000} +: 16]};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_access_ctrl.sv
// Memory-stage controller: accepts one load/store, issues one or two beats on
// the data-memory port, stalls the pipeline and returns load data for writeback.
module mem_stage_access_ctrl
  import mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        Enable_In,
  input  logic        rw_In,
  input  logic        Load_In,
  input  logic [1:0]  Size_In,
  input  logic [31:0] Addr_In,
  input  logic [31:0] StoreLo_In,
  input  logic [31:0] StoreHi_In,
  input  logic [3:0]  Rd_In,
  output logic        Stall_Out,
  mem_stage_access_ctrl_if.master mem,
  output logic        LoadValid_Out,
  output logic [31:0] LoadLo_Out,
  output logic [31:0] LoadHi_Out,
  output logic [3:0]  Rd_Out,
  output logic        Fault_Out
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  state_e      state_q, state_d;
  logic        rw_q, rw_d, load_q, load_d, fault_q, fault_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d, slo_q, slo_d, shi_q, shi_d;
  logic [31:0] lo_stage_q, lo_stage_d, load_lo_q, load_lo_d, load_hi_q, load_hi_d;
  logic [3:0]  rd_q, rd_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic        req;
  logic [3:0]  be;
  logic [31:0] wdata, rdata_ext;

  mem_lane_align u_align (
    .size_i    (size_q),
    .addr_lo_i (addr_q[1:0]),
    .wdata_i   ((state_q == BEAT1) ? shi_q : slo_q),
    .rdata_i   (mem.Mem_RData_In),
    .be_o      (be),
    .wdata_o   (wdata),
    .rdata_o   (rdata_ext)
  );

  always_comb begin
    state_d    = state_q;
    rw_d       = rw_q;
    load_d     = load_q;
    fault_d    = fault_q;
    size_d     = size_q;
    addr_d     = addr_q;
    slo_d      = slo_q;
    shi_d      = shi_q;
    rd_d       = rd_q;
    lo_stage_d = lo_stage_q;
    load_lo_d  = load_lo_q;
    load_hi_d  = load_hi_q;
    tmo_d      = tmo_q;
    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (Enable_In) begin
          rw_d    = rw_In;
          load_d  = Load_In;
          size_d  = Size_In;
          addr_d  = Addr_In;
          slo_d   = StoreLo_In;
          shi_d   = StoreHi_In;
          rd_d    = Rd_In;
          fault_d = misaligned(Size_In, Addr_In[2:0]);
          state_d = misaligned(Size_In, Addr_In[2:0]) ? DONE : BEAT0;
        end
      end
      BEAT0, BEAT1: begin
        if (mem.Mem_Ack_In) begin
          tmo_d = '0;
          if (state_q == BEAT0 && size_q == SIZE_DWORD) begin
            lo_stage_d = rdata_ext;
            state_d    = BEAT1;
          end else begin
            // Outputs update only on completion so they hold across beat 1.
            if (load_q) begin
              load_lo_d = (size_q == SIZE_DWORD) ? lo_stage_q : rdata_ext;
              load_hi_d = (size_q == SIZE_DWORD) ? rdata_ext : 32'd0;
            end
            state_d = DONE;
          end
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          fault_d = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      DONE: begin
        fault_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state_q    <= IDLE;
      rw_q       <= 1'b0;
      load_q     <= 1'b0;
      fault_q    <= 1'b0;
      size_q     <= 2'b00;
      addr_q     <= 32'd0;
      slo_q      <= 32'd0;
      shi_q      <= 32'd0;
      rd_q       <= 4'd0;
      lo_stage_q <= 32'd0;
      load_lo_q  <= 32'd0;
      load_hi_q  <= 32'd0;
      tmo_q      <= '0;
    end else begin
      state_q    <= state_d;
      rw_q       <= rw_d;
      load_q     <= load_d;
      fault_q    <= fault_d;
      size_q     <= size_d;
      addr_q     <= addr_d;
      slo_q      <= slo_d;
      shi_q      <= shi_d;
      rd_q       <= rd_d;
      lo_stage_q <= lo_stage_d;
      load_lo_q  <= load_lo_d;
      load_hi_q  <= load_hi_d;
      tmo_q      <= tmo_d;
    end
  end

  // Bus outputs are gated by req so an idle port presents all zeros.
  assign req               = (state_q == BEAT0) || (state_q == BEAT1);
  assign mem.Mem_Req_Out   = req;
  assign mem.Mem_Write_Out = req & rw_q;
  assign mem.Mem_Addr_Out  = req ? ({addr_q[31:2], 2'b00} + ((state_q == BEAT1) ? 32'd4 : 32'd0))
                                 : 32'd0;
  assign mem.Mem_BE_Out    = req ? be : 4'd0;
  assign mem.Mem_WData_Out = (req & rw_q) ? wdata : 32'd0;

  assign Stall_Out     = ((state_q == IDLE) && Enable_In) || req;
  assign LoadValid_Out = (state_q == DONE) && load_q && !fault_q;
  assign Fault_Out     = (state_q == DONE) && fault_q;
  assign LoadLo_Out    = load_lo_q;
  assign LoadHi_Out    = load_hi_q;
  assign Rd_Out        = rd_q;

endmodule

// File: tb/tb_mem_stage_access_ctrl.sv
// Directed scoreboard bench for mem_stage_access_ctrl: expected beats and load
// results are queued when an op is driven and checked as the DUT produces them.
module tb_mem_stage_access_ctrl;

  logic        clk = 1'b0;
  logic        clr;
  logic        en_i, rw_i, ld_i;
  logic [1:0]  size_i;
  logic [31:0] addr_i, slo_i, shi_i;
  logic [3:0]  rd_i;
  logic        stall_o, lv_o, fault_o;
  logic [31:0] lo_o, hi_o;
  logic [3:0]  rd_o;

  always #5 clk = ~clk;

  mem_stage_access_ctrl_if bus ();

  mem_stage_access_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .CLK(clk), .CLR(clr),
    .Enable_In(en_i), .rw_In(rw_i), .Load_In(ld_i), .Size_In(size_i),
    .Addr_In(addr_i), .StoreLo_In(slo_i), .StoreHi_In(shi_i), .Rd_In(rd_i),
    .Stall_Out(stall_o), .mem(bus),
    .LoadValid_Out(lv_o), .LoadLo_Out(lo_o), .LoadHi_Out(hi_o),
    .Rd_Out(rd_o), .Fault_Out(fault_o)
  );

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          wait_n;
  } beat_t;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic [3:0]  rd;
  } ld_t;

  beat_t beat_q[$];
  ld_t   ld_q[$];
  int total = 0;
  int bad   = 0;
  logic [31:0] m_lo, m_hi;
  localparam int NEVER = 1000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic m_misal(input logic [1:0] sz, input logic [31:0] a);
    case (sz)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      2'b10:   return a[1:0] != 2'b00;
      default: return a[2:0] != 3'b000;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'b00: case (a)
               2'd0: return 4'b0001;
               2'd1: return 4'b0010;
               2'd2: return 4'b0100;
               default: return 4'b1000;
             endcase
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'b00:   return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01:   return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] sz, input logic [1:0] a, input logic [31:0] d);
    case (sz)
      2'b00: case (a)
               2'd0: return {24'd0, d[7:0]};
               2'd1: return {24'd0, d[15:8]};
               2'd2: return {24'd0, d[23:16]};
               default: return {24'd0, d[31:24]};
             endcase
      2'b01:   return a[1] ? {16'd0, d[31:16]} : {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic drive(input logic w, input logic [1:0] sz, input logic [31:0] a,
                       input logic [31:0] lo, input logic [31:0] hi, input logic [3:0] rdv);
    en_i = 1'b1; rw_i = w; ld_i = !w; size_i = sz; addr_i = a;
    slo_i = lo; shi_i = hi; rd_i = rdv;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, " stall"}, 32'(stall_o), 32'd0);
    chk({name, " req"},   32'(bus.Mem_Req_Out), 32'd0);
    chk({name, " write"}, 32'(bus.Mem_Write_Out), 32'd0);
    chk({name, " addr"},  bus.Mem_Addr_Out, 32'd0);
    chk({name, " be"},    32'(bus.Mem_BE_Out), 32'd0);
    chk({name, " wdata"}, bus.Mem_WData_Out, 32'd0);
    chk({name, " lv"},    32'(lv_o), 32'd0);
    chk({name, " lo"},    lo_o, 32'd0);
    chk({name, " hi"},    hi_o, 32'd0);
    chk({name, " rd"},    32'(rd_o), 32'd0);
    chk({name, " fault"}, 32'(fault_o), 32'd0);
  endtask

  task automatic run_op(input string name, input logic w, input logic [1:0] sz, input logic [31:0] a,
                        input logic [31:0] slo, input logic [31:0] shi, input logic [3:0] rdv,
                        input logic [31:0] rd0, input logic [31:0] rd1, input int w0, input int w1);
    beat_t b;
    ld_t   e;
    logic  misal, dw, tmo, done;
    int    stall_cnt, req_cnt, lv_cnt, flt_cnt, cyc, exp_stall;
    misal = m_misal(sz, a);
    dw    = (sz == 2'b11);
    tmo   = !misal && (w0 >= 16 || (dw && w1 >= 16));
    if (!misal) begin
      b.wr = w; b.addr = {a[31:2], 2'b00}; b.be = m_be(sz, a[1:0]);
      b.wdata = m_wdata(sz, slo); b.rdata = rd0; b.wait_n = w0;
      beat_q.push_back(b);
      if (dw) begin
        b.addr = b.addr + 32'd4; b.be = 4'hF; b.wdata = shi; b.rdata = rd1; b.wait_n = w1;
        beat_q.push_back(b);
      end
    end
    if (!w && !misal && !tmo) begin
      e.lo = dw ? rd0 : m_load(sz, a[1:0], rd0);
      e.hi = dw ? rd1 : 32'd0;
      e.rd = rdv;
      ld_q.push_back(e);
    end
    if (misal)             exp_stall = 1;
    else if (w0 >= 16)     exp_stall = 1 + 16;
    else if (!dw)          exp_stall = 1 + w0 + 1;
    else if (w1 >= 16)     exp_stall = 1 + w0 + 1 + 16;
    else                   exp_stall = 1 + w0 + 1 + w1 + 1;

    @(negedge clk);
    drive(w, sz, a, slo, shi, rdv);
    bus.Mem_Ack_In = 1'b0;
    #1;
    stall_cnt = stall_o ? 1 : 0;
    req_cnt = 0; lv_cnt = 0; flt_cnt = 0; cyc = 0; done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (lv_o) lv_cnt++;
      if (fault_o) flt_cnt++;
      if (!stall_o) begin
        done = 1'b1; en_i = 1'b0; bus.Mem_Ack_In = 1'b0;
        chk({name, " req_in_done"}, 32'(bus.Mem_Req_Out), 32'd0);
        if (lv_o) begin
          if (ld_q.size() == 0) chk({name, " unexpected_lv"}, 32'(lv_o), 32'd0);
          else begin
            e = ld_q.pop_front();
            chk({name, " load_lo"}, lo_o, e.lo);
            chk({name, " load_hi"}, hi_o, e.hi);
            chk({name, " rd_out"}, 32'(rd_o), 32'(e.rd));
            m_lo = e.lo; m_hi = e.hi;
          end
        end else begin
          chk({name, " lo_hold"}, lo_o, m_lo);
          chk({name, " hi_hold"}, hi_o, m_hi);
        end
      end else begin
        stall_cnt++;
        if (bus.Mem_Req_Out) begin
          req_cnt++;
          if (beat_q.size() == 0) begin
            bus.Mem_Ack_In = 1'b0;
            chk({name, " unexpected_req"}, 32'(bus.Mem_Req_Out), 32'd0);
          end else begin
            b = beat_q[0];
            chk({name, " addr"},  bus.Mem_Addr_Out, b.addr);
            chk({name, " be"},    32'(bus.Mem_BE_Out), 32'(b.be));
            chk({name, " write"}, 32'(bus.Mem_Write_Out), 32'(b.wr));
            if (b.wr) chk({name, " wdata"}, bus.Mem_WData_Out, b.wdata);
            if (cyc == b.wait_n) begin
              bus.Mem_Ack_In = 1'b1; bus.Mem_RData_In = b.rdata;
              void'(beat_q.pop_front());
              cyc = 0;
            end else begin
              bus.Mem_Ack_In = 1'b0;
              cyc++;
            end
          end
        end else begin
          bus.Mem_Ack_In = 1'b0;
        end
      end
    end
    if (!done) begin
      en_i = 1'b0; bus.Mem_Ack_In = 1'b0;
      chk({name, " op_timeout"}, 32'(stall_o), 32'd0);
    end
    if (tmo) beat_q.delete();
    chk({name, " stall_cycles"}, 32'(stall_cnt), 32'(exp_stall));
    chk({name, " req_cycles"},   32'(req_cnt), 32'(exp_stall - 1));
    chk({name, " lv_pulses"},    32'(lv_cnt), 32'(!w && !misal && !tmo));
    chk({name, " fault_pulses"}, 32'(flt_cnt), 32'(misal || tmo));
    chk({name, " beats_left"},   32'(beat_q.size()), 32'd0);
    @(negedge clk);
    chk({name, " idle_stall"}, 32'(stall_o), 32'd0);
    chk({name, " idle_lv"},    32'(lv_o), 32'd0);
    chk({name, " idle_fault"}, 32'(fault_o), 32'd0);
    chk({name, " idle_lo"},    lo_o, m_lo);
    $display("op %s: addr=0x%08h size=%0d rw=%0d stall=%0d lo=0x%08h hi=0x%08h",
             name, a, sz, w, stall_cnt, lo_o, hi_o);
  endtask

  initial begin
    clr = 1'b1; en_i = 1'b0; rw_i = 1'b0; ld_i = 1'b0; size_i = 2'b00;
    addr_i = 32'd0; slo_i = 32'd0; shi_i = 32'd0; rd_i = 4'd0;
    bus.Mem_Ack_In = 1'b0; bus.Mem_RData_In = 32'd0;
    m_lo = 32'd0; m_hi = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;

    run_op("st_byte",   1'b1, 2'b00, 32'h0000_1003, 32'h0000_00A5, 32'h0, 4'd1, 32'h0, 32'h0, 0, 0);
    run_op("ld_word",   1'b0, 2'b10, 32'h0000_2000, 32'h0, 32'h0, 4'd5, 32'hDEAD_BEEF, 32'h0, 2, 0);
    run_op("ld_half",   1'b0, 2'b01, 32'h0000_2002, 32'h0, 32'h0, 4'd6, 32'h8001_7FFF, 32'h0, 1, 0);
    run_op("st_dword",  1'b1, 2'b11, 32'h0000_3000, 32'h1111_1111, 32'h2222_2222, 4'd2, 32'h0, 32'h0, 0, 1);
    run_op("ld_misal",  1'b0, 2'b10, 32'h0000_2001, 32'h0, 32'h0, 4'd7, 32'h0, 32'h0, 0, 0);
    run_op("ld_tmo",    1'b0, 2'b10, 32'h0000_2004, 32'h0, 32'h0, 4'd8, 32'h1234_5678, 32'h0, NEVER, 0);
    run_op("ld_byte3",  1'b0, 2'b00, 32'h0000_5003, 32'h0, 32'h0, 4'd3, 32'hC3B2_A190, 32'h0, 0, 0);
    run_op("ld_dword",  1'b0, 2'b11, 32'h0000_6000, 32'h0, 32'h0, 4'd12, 32'hCAFE_F00D, 32'h0BAD_BEEF, 1, 0);
    run_op("st_half",   1'b1, 2'b01, 32'h0000_7002, 32'h0000_BEEF, 32'h0, 4'd4, 32'h0, 32'h0, 0, 0);
    run_op("dw_misal",  1'b1, 2'b11, 32'h0000_6004, 32'h0, 32'h0, 4'd4, 32'h0, 32'h0, 0, 0);

    // Reset while the first beat of a load is outstanding.
    @(negedge clk);
    drive(1'b0, 2'b10, 32'h0000_4000, 32'h0, 32'h0, 4'd9);
    bus.Mem_Ack_In = 1'b0;
    @(negedge clk);
    chk("clr_beat0 req", 32'(bus.Mem_Req_Out), 32'd1);
    clr = 1'b1; en_i = 1'b0;
    @(negedge clk);
    chk_all_zero("clr_beat0");
    clr = 1'b0;
    m_lo = 32'd0; m_hi = 32'd0;
    $display("op clr_beat0: reset during beat0 of load at 0x00004000");

    run_op("ld_after_clr", 1'b0, 2'b10, 32'h0000_4008, 32'h0, 32'h0, 4'd10, 32'h5A5A_0F0F, 32'h0, 0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
